march_bist: RTL and testbench

MARCH_BIST -- requirements
Module: march_bist

---
 rtl/march_bist_pkg.sv | 77 +++++++
 rtl/march_bist_seq.sv | 69 ++++++
 rtl/march_bist.sv | 177 +++++++++++++++++
 tb/tb_march_bist.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/march_bist_pkg.sv
// Shared definitions for the march BIST: FSM states, configuration codes and
// the march element tables for March C- and MATS+.
package march_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    ALG_MARCH_CM = 1'b0,
    ALG_MATS_P   = 1'b1
  } algo_e;

  typedef enum logic {
    BG_SOLID   = 1'b0,
    BG_CHECKER = 1'b1
  } bg_e;

  localparam int unsigned MARCH_CM_ELEMS = 6;
  localparam int unsigned MATS_P_ELEMS   = 3;

  // One memory operation: read/write and the logical value written or expected.
  typedef struct packed {
    logic rd;
    logic val;
  } mop_t;

  typedef struct packed {
    logic down;
    logic two_ops;
    mop_t op0;
    mop_t op1;
  } elem_t;

  localparam mop_t OP_W0 = 2'b00;
  localparam mop_t OP_W1 = 2'b01;
  localparam mop_t OP_R0 = 2'b10;
  localparam mop_t OP_R1 = 2'b11;

  function automatic elem_t elem_lookup(algo_e algo, logic [2:0] idx);
    elem_t e;
    e = '0;
    if (algo == ALG_MATS_P) begin
      case (idx)
        3'd0:    e = {1'b0, 1'b0, OP_W0, OP_W0};
        3'd1:    e = {1'b0, 1'b1, OP_R0, OP_W1};
        3'd2:    e = {1'b1, 1'b1, OP_R1, OP_W0};
        default: e = '0;
      endcase
    end else begin
      case (idx)
        3'd0:    e = {1'b0, 1'b0, OP_W0, OP_W0};
        3'd1:    e = {1'b0, 1'b1, OP_R0, OP_W1};
        3'd2:    e = {1'b0, 1'b1, OP_R1, OP_W0};
        3'd3:    e = {1'b1, 1'b1, OP_R0, OP_W1};
        3'd4:    e = {1'b1, 1'b1, OP_R1, OP_W0};
        3'd5:    e = {1'b0, 1'b0, OP_R0, OP_R0};
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  function automatic logic elem_is_down(algo_e algo, logic [2:0] idx);
    elem_t e;
    e = elem_lookup(algo, idx);
    return e.down;
  endfunction

  function automatic logic [2:0] last_elem(algo_e algo);
    return (algo == ALG_MATS_P) ? 3'(MATS_P_ELEMS - 1) : 3'(MARCH_CM_ELEMS - 1);
  endfunction

endpackage

// File: rtl/march_bist_seq.sv
// March sequencer: walks element / operation / address for the selected
// algorithm, one step per issued memory operation.
module march_seq
  import march_bist_pkg::*;
#(
  parameter int ADR_SIZE = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                launch_i,
  input  logic                step_i,
  input  algo_e               algo_i,
  output logic [2:0]          elem_o,
  output logic [ADR_SIZE-1:0] adr_o,
  output mop_t                op_o,
  output logic                last_o
);

  logic [2:0]          elem_q, elem_d;
  logic                opi_q, opi_d;
  logic [ADR_SIZE-1:0] adr_q, adr_d;
  elem_t               cur;
  logic                op_end, adr_end, elem_end;

  always_comb begin
    cur      = elem_lookup(algo_i, elem_q);
    op_end   = !cur.two_ops || opi_q;
    adr_end  = cur.down ? (adr_q == '0) : (adr_q == '1);
    elem_end = (elem_q == last_elem(algo_i));
    elem_d   = elem_q;
    opi_d    = opi_q;
    adr_d    = adr_q;
    if (launch_i) begin
      elem_d = '0;
      opi_d  = 1'b0;
      adr_d  = '0;
    end else if (step_i) begin
      if (!op_end) begin
        opi_d = 1'b1;
      end else begin
        opi_d = 1'b0;
        if (!adr_end) begin
          adr_d = cur.down ? adr_q - ADR_SIZE'(1) : adr_q + ADR_SIZE'(1);
        end else begin
          // Wrap moves straight into the next element's start address.
          elem_d = elem_q + 3'd1;
          adr_d  = elem_is_down(algo_i, elem_q + 3'd1) ? '1 : '0;
        end
      end
    end
    elem_o = elem_q;
    adr_o  = adr_q;
    op_o   = opi_q ? cur.op1 : cur.op0;
    last_o = op_end && adr_end && elem_end;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elem_q <= '0;
      opi_q  <= 1'b0;
      adr_q  <= '0;
    end else begin
      elem_q <= elem_d;
      opi_q  <= opi_d;
      adr_q  <= adr_d;
    end
  end

endmodule

// File: rtl/march_bist.sv
// March BIST controller: run FSM, registered memory port, read-compare
// pipeline and first-fail capture around the march_seq sequencer.
module march_bist
  import march_bist_pkg::*;
#(
  parameter int ADR_SIZE  = 4,
  parameter int DATA_SIZE = 8,
  parameter int CNT_SIZE  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 algo_sel_i,
  input  logic                 bg_sel_i,
  input  logic                 stop_on_fail_i,
  output logic [ADR_SIZE-1:0]  mem_adr_o,
  output logic [DATA_SIZE-1:0] mem_wdata_o,
  output logic                 mem_wr_en_o,
  output logic                 mem_rd_en_o,
  input  logic [DATA_SIZE-1:0] mem_rdata_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 status_o,
  output logic [CNT_SIZE-1:0]  fail_cnt_o,
  output logic [ADR_SIZE-1:0]  fail_adr_o,
  output logic [2:0]           fail_elem_o,
  output logic [DATA_SIZE-1:0] fail_syn_o
);

  function automatic logic [DATA_SIZE-1:0] bg_word(bg_e bg, logic [ADR_SIZE-1:0] adr, logic val);
    logic [DATA_SIZE-1:0] w;
    for (int i = 0; i < DATA_SIZE; i++) w[i] = (bg == BG_CHECKER) && (i[0] == adr[0]);
    return val ? ~w : w;
  endfunction

  state_e               state_q, state_d;
  algo_e                algo_q, algo_d;
  bg_e                  bg_q, bg_d;
  logic                 sof_q, sof_d, seq_end_q, seq_end_d;
  logic [ADR_SIZE-1:0]  mem_adr_q, mem_adr_d;
  logic [DATA_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [1:0]           rd_pipe_q, rd_pipe_d;
  logic [1:0][DATA_SIZE-1:0] exp_pipe_q;
  logic [1:0][2:0]      elem_pipe_q;
  logic [ADR_SIZE-1:0]  cmp_adr_q;
  logic [CNT_SIZE-1:0]  fail_cnt_q, fail_cnt_d;
  logic [ADR_SIZE-1:0]  fail_adr_q, fail_adr_d;
  logic [2:0]           fail_elem_q, fail_elem_d;
  logic [DATA_SIZE-1:0] fail_syn_q, fail_syn_d;

  logic [2:0]           seq_elem;
  logic [ADR_SIZE-1:0]  seq_adr;
  mop_t                 seq_op;
  logic                 seq_last, busy, launch, mis, issue;
  logic [DATA_SIZE-1:0] seq_word;

  march_seq #(.ADR_SIZE(ADR_SIZE)) u_seq (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .launch_i (launch),
    .step_i   (issue),
    .algo_i   (algo_q),
    .elem_o   (seq_elem),
    .adr_o    (seq_adr),
    .op_o     (seq_op),
    .last_o   (seq_last)
  );

  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign launch   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_i;
  assign mis      = busy && rd_pipe_q[1] && (mem_rdata_i != exp_pipe_q[1]);
  // A stopping mismatch suppresses the op that would follow it.
  assign issue    = (state_q == ST_RUN) && !seq_end_q && !(sof_q && mis);
  assign seq_word = bg_word(bg_q, seq_adr, seq_op.val);

  always_comb begin
    state_d   = state_q;
    algo_d    = algo_q;
    bg_d      = bg_q;
    sof_d     = sof_q;
    seq_end_d = seq_end_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_i) begin
        state_d   = ST_RUN;
        algo_d    = algo_e'(algo_sel_i);
        bg_d      = bg_e'(bg_sel_i);
        sof_d     = stop_on_fail_i;
        seq_end_d = 1'b0;
      end
      ST_RUN: begin
        if (issue && seq_last) seq_end_d = 1'b1;
        if (seq_end_q || (sof_q && mis)) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    mem_adr_d   = issue ? seq_adr : mem_adr_q;
    mem_wdata_d = (issue && !seq_op.rd) ? seq_word : mem_wdata_q;
    mem_wr_d    = issue && !seq_op.rd;
    rd_pipe_d   = {rd_pipe_q[0], issue && seq_op.rd};

    fail_cnt_d  = fail_cnt_q;
    fail_adr_d  = fail_adr_q;
    fail_elem_d = fail_elem_q;
    fail_syn_d  = fail_syn_q;
    if (launch) begin
      fail_cnt_d  = '0;
      fail_adr_d  = '0;
      fail_elem_d = '0;
      fail_syn_d  = '0;
    end else if (mis) begin
      if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_SIZE'(1);
      if (fail_cnt_q == '0) begin
        fail_adr_d  = cmp_adr_q;
        fail_elem_d = elem_pipe_q[1];
        fail_syn_d  = exp_pipe_q[1] ^ mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      algo_q      <= ALG_MARCH_CM;
      bg_q        <= BG_SOLID;
      sof_q       <= 1'b0;
      seq_end_q   <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      rd_pipe_q   <= '0;
      exp_pipe_q  <= '0;
      elem_pipe_q <= '0;
      cmp_adr_q   <= '0;
      fail_cnt_q  <= '0;
      fail_adr_q  <= '0;
      fail_elem_q <= '0;
      fail_syn_q  <= '0;
    end else begin
      state_q     <= state_d;
      algo_q      <= algo_d;
      bg_q        <= bg_d;
      sof_q       <= sof_d;
      seq_end_q   <= seq_end_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      rd_pipe_q   <= rd_pipe_d;
      if (issue) begin
        exp_pipe_q[0]  <= seq_word;
        elem_pipe_q[0] <= seq_elem;
      end
      exp_pipe_q[1]  <= exp_pipe_q[0];
      elem_pipe_q[1] <= elem_pipe_q[0];
      cmp_adr_q      <= mem_adr_q;
      fail_cnt_q  <= fail_cnt_d;
      fail_adr_q  <= fail_adr_d;
      fail_elem_q <= fail_elem_d;
      fail_syn_q  <= fail_syn_d;
    end
  end

  assign mem_adr_o   = mem_adr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wr_en_o = mem_wr_q;
  assign mem_rd_en_o = rd_pipe_q[0];
  assign busy_o      = busy;
  assign done_o      = (state_q == ST_DONE);
  assign status_o    = (state_q == ST_DONE) && (fail_cnt_q == '0);
  assign fail_cnt_o  = fail_cnt_q;
  assign fail_adr_o  = fail_adr_q;
  assign fail_elem_o = fail_elem_q;
  assign fail_syn_o  = fail_syn_q;

endmodule

// File: tb/tb_march_bist.sv
// Randomized bench for march_bist: a faulty-memory model drives the DUT and a
// march-notation reference model predicts the op stream, latency and results.
module tb_march_bist;
  localparam int N = 16;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic       algo_sel = 1'b0, bg_sel = 1'b0, sof = 1'b0;
  logic [3:0] mem_adr, fail_adr;
  logic [7:0] mem_wdata, mem_rdata, fail_cnt, fail_syn;
  logic       mem_wr, mem_rd, busy, done, status;
  logic [2:0] fail_elem;
  int         n_tests = 0, n_fail = 0;

  march_bist dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .algo_sel_i(algo_sel),
    .bg_sel_i(bg_sel), .stop_on_fail_i(sof), .mem_adr_o(mem_adr),
    .mem_wdata_o(mem_wdata), .mem_wr_en_o(mem_wr), .mem_rd_en_o(mem_rd),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .done_o(done), .status_o(status),
    .fail_cnt_o(fail_cnt), .fail_adr_o(fail_adr), .fail_elem_o(fail_elem),
    .fail_syn_o(fail_syn)
  );

  always #5 clk = ~clk;

  // Memory with one optional stuck-at bit.
  logic [7:0] mem [N];
  bit         f_en = 0, f_sa1 = 0;
  logic [3:0] f_adr = '0;
  logic [7:0] f_mask = '0;

  function automatic logic [7:0] faulty(logic [3:0] a, logic [7:0] d);
    if (!f_en || a != f_adr) return d;
    return f_sa1 ? (d | f_mask) : (d & ~f_mask);
  endfunction

  always @(posedge clk) begin
    if (mem_wr) mem[mem_adr] <= mem_wdata;
    if (mem_rd) mem_rdata <= faulty(mem_adr, mem[mem_adr]);
  end

  typedef struct {int elem; bit rd; int adr; logic [7:0] d;} op_t;
  typedef struct {bit rd; int adr; logic [7:0] d;} obs_t;
  op_t  exp_ops[$];
  obs_t obs_ops[$];
  int   both_hi = 0;
  bit   mon_en = 0;

  always @(negedge clk) if (mon_en) begin
    if (mem_wr && mem_rd) both_hi++;
    if (mem_wr || mem_rd) obs_ops.push_back('{rd: mem_rd, adr: int'(mem_adr), d: mem_rd ? 8'h00 : mem_wdata});
  end

  task automatic chk(string tag, longint act, longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic string elem_str(bit algo, int e);
    if (algo) begin
      case (e)
        0: return "Uw0";
        1: return "Ur0w1";
        default: return "Dr1w0";
      endcase
    end
    case (e)
      0: return "Uw0";
      1: return "Ur0w1";
      2: return "Ur1w0";
      3: return "Dr0w1";
      4: return "Dr1w0";
      default: return "Ur0";
    endcase
  endfunction

  function automatic logic [7:0] word(bit bg, int adr, bit v);
    logic [7:0] w;
    w = bg ? ((adr % 2 == 0) ? 8'h55 : 8'hAA) : 8'h00;
    return v ? ~w : w;
  endfunction

  int m_done, m_cnt, m_adr, m_elem, m_syn;

  // Expands the march notation into ops, plays them on an ideal copy of the
  // faulty memory, and derives the expected outcome and done latency.
  task automatic model(bit algo, bit bg, bit stop);
    op_t        all[$];
    logic [7:0] m [N];
    logic [7:0] got;
    int         lim, first;
    exp_ops.delete();
    for (int e = 0; e < (algo ? 3 : 6); e++) begin
      string s;
      int    nops;
      s = elem_str(algo, e);
      nops = (s.len() - 1) / 2;
      for (int a = 0; a < N; a++) begin
        int adr;
        adr = (s.getc(0) == "D") ? N - 1 - a : a;
        for (int k = 0; k < nops; k++) begin
          op_t o;
          o.elem = e;
          o.rd   = (s.getc(1 + 2 * k) == "r");
          o.adr  = adr;
          o.d    = word(bg, adr, s.getc(2 + 2 * k) == "1");
          all.push_back(o);
        end
      end
    end
    m_cnt = 0; m_adr = 0; m_elem = 0; m_syn = 0; first = -1;
    lim = all.size() - 1;
    for (int i = 0; i <= lim && i < all.size(); i++) begin
      exp_ops.push_back(all[i]);
      if (!all[i].rd) m[all[i].adr] = all[i].d;
      else begin
        got = faulty(4'(all[i].adr), m[all[i].adr]);
        if (got != all[i].d) begin
          if (first < 0) begin
            first  = i;
            m_adr  = all[i].adr;
            m_elem = all[i].elem;
            m_syn  = int'(got ^ all[i].d);
            // The op already on the bus while the mismatch is seen still runs.
            if (stop) lim = i + 1;
          end
          m_cnt++;
        end
      end
    end
    m_done = all.size() + 2;
    if (stop && first >= 0 && first + 4 < m_done) m_done = first + 4;
  endtask

  task automatic run(string tag, bit algo, bit bg, bit stop, bit poke);
    int e_cnt, got_done, pk, errs, n;
    model(algo, bg, stop);
    obs_ops.delete();
    both_hi = 0;
    errs = 0;
    @(negedge clk);
    algo_sel = algo; bg_sel = bg; sof = stop; start = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; algo_sel = ~algo; bg_sel = ~bg; sof = ~stop;
    chk({tag, ".busy"}, busy, 1);
    pk = poke ? $urandom_range(m_done - 1, 1) : -1;
    e_cnt = 0; got_done = -1;
    while (got_done < 0 && e_cnt < 3000) begin
      @(posedge clk); #1;
      e_cnt++;
      start = (e_cnt == pk);
      if (done) got_done = e_cnt;
    end
    start = 1'b0;
    chk({tag, ".done_edge"}, got_done, m_done);
    @(posedge clk); #1;
    mon_en = 1'b0;
    chk({tag, ".done_hold"}, {busy, done}, 2'b01);
    chk({tag, ".status"}, status, m_cnt == 0);
    chk({tag, ".fail_cnt"}, fail_cnt, m_cnt);
    chk({tag, ".fail_adr"}, fail_adr, m_adr);
    chk({tag, ".fail_elem"}, fail_elem, m_elem);
    chk({tag, ".fail_syn"}, fail_syn, m_syn);
    chk({tag, ".strobes"}, obs_ops.size(), exp_ops.size());
    chk({tag, ".both_hi"}, both_hi, 0);
    n = (obs_ops.size() < exp_ops.size()) ? obs_ops.size() : exp_ops.size();
    for (int i = 0; i < n; i++)
      if (obs_ops[i].rd != exp_ops[i].rd || obs_ops[i].adr != exp_ops[i].adr ||
          (!exp_ops[i].rd && obs_ops[i].d != exp_ops[i].d)) errs++;
    chk({tag, ".op_seq"}, errs, 0);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, ".strobes"}, {mem_wr, mem_rd}, 0);
    chk({tag, ".adr_wdata"}, {mem_adr, mem_wdata}, 0);
    chk({tag, ".busy_done_status"}, {busy, done, status}, 0);
    chk({tag, ".fail_cnt"}, fail_cnt, 0);
    chk({tag, ".fail_regs"}, {fail_adr, fail_elem, fail_syn}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_reset("rst");
    @(negedge clk) rst_n = 1'b1;
    run("marchc_solid", 0, 0, 0, 0);
    run("mats_solid", 1, 0, 0, 1);
    f_en = 1; f_adr = 4'd5; f_mask = 8'h08; f_sa1 = 1;
    run("sa1_marchc_solid", 0, 0, 0, 0);
    run("sa1_marchc_chk", 0, 1, 0, 1);
    run("sa1_stop", 0, 0, 1, 0);
    f_en = 0;
    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    algo_sel = 0; bg_sel = 0; sof = 0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    @(negedge clk) rst_n = 1'b1;
    run("after_rst", 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      f_en   = $urandom_range(1, 0);
      f_adr  = 4'($urandom_range(N - 1, 0));
      f_mask = 8'(1 << $urandom_range(7, 0));
      f_sa1  = $urandom_range(1, 0);
      run("rnd", 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
          1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
